// File: rtl/reg_wr_sched_if.sv
// ----------------------------------------------------------------------------
// reg_wr_sched_if
//
// Requester-side bundle for the register-file write-port scheduler. Two
// write-back sources share it:
//   A (ALU write-back):         a_valid, a_addr, a_data  -> scheduler
//                               a_ready                  <- scheduler
//   B (memory-load write-back): b_valid, b_addr, b_data  -> scheduler
//                               b_ready                  <- scheduler
//
// Modports:
//   master - the datapath side that raises requests and watches ready.
//   slave  - the scheduler side that observes requests and returns ready.
//
// Parameter pw sets the address width to pw+1 bits.
// ----------------------------------------------------------------------------
interface reg_wr_sched_if #(
    parameter int unsigned pw = 2
);
    logic          a_valid;
    logic [pw:0]   a_addr;
    logic [7:0]    a_data;
    logic          a_ready;

    logic          b_valid;
    logic [pw:0]   b_addr;
    logic [7:0]    b_data;
    logic          b_ready;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/reg_wr_sched.sv
// ----------------------------------------------------------------------------
// reg_wr_sched
//
// Shares the single write port of the 8-bit register file between two
// requesters (A: ALU write-back, B: memory-load write-back) using round-robin
// arbitration over a valid/ready handshake. After every reset it sweeps the
// whole file writing 0x00 so every register starts from a known value.
//
// Ports:
//   clk_i      clock, rising edge
//   reset_i    synchronous active-high reset, dominates all other inputs
//   freeze_i   core stall; blocks new grants while high
//   req        requester bundle (reg_wr_sched_if.slave)
//   wr_en_o    register-file write enable (registered)
//   wr_addr_o  register-file write address (registered)
//   dat_in_o   register-file write data (registered)
//   busy_o     clear sweep in progress
//   last_b_o   most recent grant went to B
// ----------------------------------------------------------------------------
module reg_wr_sched #(
    parameter int unsigned pw = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            freeze_i,
    reg_wr_sched_if.slave   req,
    output logic            wr_en_o,
    output logic [pw:0]     wr_addr_o,
    output logic [7:0]      dat_in_o,
    output logic            busy_o,
    output logic            last_b_o
);

    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

    state_e        state_q, state_d;

    logic [pw:0]   clr_ptr_q, clr_ptr_d;
    logic          wr_en_q, wr_en_d;
    logic [pw:0]   wr_addr_q, wr_addr_d;
    logic [7:0]    dat_in_q, dat_in_d;
    logic          last_b_q, last_b_d;

    logic          a_ready, b_ready;
    logic          a_acc, b_acc;
    logic          clr_last;

    assign clr_last = (clr_ptr_q == {(pw + 1){1'b1}});

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: if (clr_last) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (combinational ready / busy)
    // ------------------------------------------------------------------------
    // A tie goes to whichever requester did not win last; a lone requester is
    // ready whenever the core is not frozen.
    always_comb begin
        busy_o  = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        unique case (state_q)
            StClear: begin
                busy_o = 1'b1;
            end
            StRun: begin
                a_ready = !freeze_i && (!req.b_valid || last_b_q);
                b_ready = !freeze_i && (!req.a_valid || !last_b_q);
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    assign req.a_ready = a_ready;
    assign req.b_ready = b_ready;

    assign a_acc = req.a_valid && a_ready;
    assign b_acc = req.b_valid && b_ready;

    // ------------------------------------------------------------------------
    // Write-port datapath: next state
    // ------------------------------------------------------------------------
    always_comb begin
        clr_ptr_d = clr_ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        dat_in_d  = dat_in_q;
        last_b_d  = last_b_q;

        if (state_q == StClear) begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_ptr_q;
            dat_in_d  = 8'h00;
            // Wraps to 0 after the last register; unused until next reset.
            clr_ptr_d = clr_ptr_q + 1'b1;
        end else if (a_acc) begin
            wr_en_d   = 1'b1;
            wr_addr_d = req.a_addr;
            dat_in_d  = req.a_data;
            last_b_d  = 1'b0;
        end else if (b_acc) begin
            wr_en_d   = 1'b1;
            wr_addr_d = req.b_addr;
            dat_in_d  = req.b_data;
            last_b_d  = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Write-port datapath: registers
    // ------------------------------------------------------------------------
    // last_b resets to 1 so A wins the first tie after the sweep.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clr_ptr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            dat_in_q  <= 8'h00;
            last_b_q  <= 1'b1;
        end else begin
            clr_ptr_q <= clr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            dat_in_q  <= dat_in_d;
            last_b_q  <= last_b_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign dat_in_o  = dat_in_q;
    assign last_b_o  = last_b_q;

    // The arbiter must never accept both requesters in one cycle.
    always_comb begin
        assert (!(a_acc && b_acc));
    end

endmodule

// File: doc/reg_wr_sched.md
# reg_wr_sched

Write-port scheduler for the 8-bit register file. Shares the file's single write port (`wr_en`/`wr_addr`/`dat_in`) between two requesters, A (ALU write-back) and B (memory-load write-back), using round-robin arbitration and a valid/ready handshake. After every reset it first runs a clear sweep that writes 0x00 to every register, so that `k`, `b` and all other registers start from a known value. It sits between the datapath write-back sources and the register file's write inputs.

## Interface
- `pw`, 2, register address width is pw+1 bits, giving 2**(pw+1) registers (8 by default)
- `clk`  input  1  clock; everything updates on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `freeze`  input  1  core stall; while high no new request is granted
- `a_valid`  input  1  requester A has a write pending
- `a_addr`  input  pw+1  A target register
- `a_data`  input  8  A write data
- `a_ready`  output  1  A's request is accepted this cycle when a_valid is also high
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same as the A ports, for requester B
- `wr_en`  output  1  register file write enable (registered)
- `wr_addr`  output  pw+1  register file write address (registered)
- `dat_in`  output  8  register file write data (registered)
- `busy`  output  1  clear sweep in progress
- `last_b`  output  1  the most recent grant went to B (round-robin state)

## Operation
- **States:** CLEAR and RUN, plus a clear pointer `clr_ptr` (pw+1 bits).
- **Reset (edge with reset=1):**
  - state=CLEAR, clr_ptr=0.
  - wr_en=0, wr_addr=0, dat_in=0.
  - last_b=1, so A wins the first tie.
  - Any request accepted but not yet presented is dropped.
  - Reset dominates every other input.
- **CLEAR:**
  - a_ready=b_ready=0 and busy=1.
  - Each edge registers wr_en=1, wr_addr=clr_ptr, dat_in=0x00, then increments clr_ptr.
  - On the edge that issues clr_ptr = 2**(pw+1)-1, go to RUN. clr_ptr wraps to 0 and is not used again until the next reset.
  - freeze and the valid inputs are ignored in CLEAR.
- **RUN, ready rules (combinational):**
  - busy=0.
  - a_ready = !freeze && (!b_valid || last_b).
  - b_ready = !freeze && (!a_valid || !last_b).
  - A ready may be high while its valid is low. At most one valid&&ready pair can be true in any cycle.
- **RUN, on an acceptance edge (x_valid && x_ready):**
  - Register wr_en=1, wr_addr=x_addr, dat_in=x_data.
  - last_b = 1 if x is B, 0 if x is A.
- **RUN, on an edge with no acceptance:** register wr_en=0. wr_addr and dat_in hold their previous values. last_b holds.
- **Throughput:** one write per cycle sustained. A requester that is denied must hold its valid, addr and data stable until it is accepted.
- **Same address, both requesters:** no merging. Writes are serialized in grant order, so the later grant's data ends up in the register.
- **Width:** addresses and data pass through unmodified; there is no arithmetic on the data.

## Timing
- **Clear sweep:** with reset deasserted in cycle C0, wr_en=1 in cycles C1..C8 with wr_addr=0..7, and busy=1 in C0..C7.
  - busy=0 from C8; grants are possible from C8.
  - A write accepted at the end of C8 appears in C9. There is no overlap with the last clear write.
- **Grant latency:** a request accepted at edge N drives wr_en/wr_addr/dat_in during cycle N+1. The register file stores it at edge N+2.
- **freeze:**
  - Rising freeze blocks acceptance in the same cycle, because the ready signals are combinational.
  - A write already registered still completes.
- **Reset mid-operation:** when a reset edge falls while a write is presented on wr_en, that write still commits to the file at the same edge (the file samples concurrently). Every write after it is suppressed and the clear sweep restarts.

## Test plan
- **Clear sweep:** hold reset for 2 cycles, release, with both valids low. Expect wr_en=1 for exactly 8 consecutive cycles with wr_addr 0..7 and dat_in=0x00, busy falling after addr 7 is issued, and all 8 registers (including k and b) reading 0x00.
- **Single requester:** after the clear, A sends addr 3 / 0x5A. Expect a_ready=1 and, one cycle later, wr_en=1, wr_addr=3, dat_in=0x5A, then reg 3 reading 0x5A.
- **Round robin:** A (addr 2, 0x11) and B (addr 4, 0x22) both valid and held for 4 cycles, each re-presenting after acceptance. Expect grants in the order A, B, A, B, with last_b toggling 0, 1, 0, 1.
- **Same-address conflict:** A (addr 1, 0xAA) and B (addr 1, 0xBB) valid together with last_b=1. Expect A granted first and B next, and b reading 0xBB afterwards.
- **freeze:** freeze=1 for 3 cycles with A valid. Expect a_ready=0 and wr_en=0 throughout. The grant happens in the cycle freeze drops.
- **Reset mid-stream:** assert reset for 1 cycle during back-to-back B writes. Expect the in-flight write to commit, no further B writes, and a full 8-write clear sweep before b_ready rises again.
